mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 193 +++++++++++++++++++
 tb/tb_mc_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle MIPS-style control unit (Moore FSM) driving datapath
//            enables, mux selects and ALU control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control #(
    parameter logic [5:0] OP_BLTZ = 6'h01,
    parameter logic [5:0] OP_J    = 6'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zout,
    input  logic       signout,
    output logic [2:0] gin,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BLTZ   = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_funct;
    logic       r_is_store;
    logic       w_funct_ok;

    function automatic logic [2:0] alu_gin(input logic [5:0] f);
        case (f)
            6'h20:   alu_gin = 3'b010;
            6'h22:   alu_gin = 3'b110;
            6'h24:   alu_gin = 3'b000;
            6'h25:   alu_gin = 3'b001;
            6'h2A:   alu_gin = 3'b111;
            default: alu_gin = 3'b010;
        endcase
    endfunction

    assign w_funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                        (funct == 6'h25) || (funct == 6'h2A);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (op == c_op_lw || op == c_op_sw)
                    w_next = S_MEMADR;
                else if (op == c_op_rtype)
                    w_next = w_funct_ok ? S_REXEC : S_FETCH;
                else if (op == c_op_beq)
                    w_next = S_BEQ;
                else if (op == OP_BLTZ)
                    w_next = S_BLTZ;
                else if (op == OP_J)
                    w_next = S_JUMP;
                else
                    w_next = S_FETCH;
            end
            // Load/store direction comes from the DECODE snapshot, not the live opcode
            S_MEMADR: w_next = r_is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_REXEC:  w_next = S_RWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_funct    <= 6'h20;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_funct    <= funct;
                r_is_store <= (op == c_op_sw);
            end
        end
    end

    always_comb begin
        gin        = 3'b010;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            // Reset presents FETCH selects with every strobe that commits state held low
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
        end else begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_en     = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = (w_next == S_FETCH);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = 1'b1;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    gin       = alu_gin(r_funct);
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    gin        = alu_gin(r_funct);
                    instr_done = 1'b1;
                end
                S_BEQ, S_BLTZ: begin
                    alu_src_a  = 1'b1;
                    gin        = 3'b110;
                    pc_source  = 2'b01;
                    pc_en      = (r_state == S_BEQ) ? zout : signout;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// Module   : tb_mc_control
// Brief    : Table-driven self-checking bench for mc_control with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zout, signout;
    logic [2:0] gin;
    logic       pc_en, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       instr_done, illegal;

    localparam logic [5:0] OP_BLTZ = 6'h01;
    localparam logic [5:0] OP_J    = 6'h02;

    mc_control #(.OP_BLTZ(OP_BLTZ), .OP_J(OP_J)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zout(zout), .signout(signout),
        .gin(gin), .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {
        P_RST, P_F, P_D, P_DILL, P_MA, P_MR, P_MWB, P_MWR, P_RX, P_RWB, P_BEQ, P_BLTZ, P_J
    } phase_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        logic       s;
        int         len;
        phase_t     ph [5];
    } vec_t;

    vec_t         tbl [$];
    logic [17:0]  sb_q [$];
    int           checks = 0;
    int           errors = 0;
    wire  [17:0]  got = {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, pc_source, gin, instr_done, illegal};

    function automatic logic [2:0] fgin(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected output word for one cycle, written from the per-state output table
    function automatic logic [17:0] exp_vec(input phase_t p, input vec_t v);
        logic pe, irw, mr, mw, iod, rw, rd, m2r, sa, dn, il;
        logic [1:0] sb, ps;
        logic [2:0] g;
        {pe, irw, mr, mw, iod, rw, rd, m2r, sa, dn, il} = '0;
        sb = 2'b00; ps = 2'b00; g = 3'b010;
        case (p)
            P_RST:  begin irw = 1; mr = 1; sb = 2'b01; end
            P_F:    begin irw = 1; mr = 1; sb = 2'b01; pe = 1; end
            P_D:    sb = 2'b11;
            P_DILL: begin sb = 2'b11; il = 1; end
            P_MA:   begin sa = 1; sb = 2'b10; end
            P_MR:   begin mr = 1; iod = 1; end
            P_MWB:  begin rw = 1; m2r = 1; dn = 1; end
            P_MWR:  begin mw = 1; iod = 1; dn = 1; end
            P_RX:   begin sa = 1; g = fgin(v.funct); end
            P_RWB:  begin rw = 1; rd = 1; g = fgin(v.funct); dn = 1; end
            P_BEQ:  begin sa = 1; g = 3'b110; ps = 2'b01; pe = v.z; dn = 1; end
            P_BLTZ: begin sa = 1; g = 3'b110; ps = 2'b01; pe = v.s; dn = 1; end
            P_J:    begin ps = 2'b10; pe = 1; dn = 1; end
            default: ;
        endcase
        return {pe, irw, mr, mw, iod, rw, rd, m2r, sa, sb, ps, g, dn, il};
    endfunction

    function automatic void add(input string n, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic s, input int len,
                                input phase_t p0, input phase_t p1, input phase_t p2,
                                input phase_t p3, input phase_t p4);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.z = z; v.s = s; v.len = len;
        v.ph[0] = p0; v.ph[1] = p1; v.ph[2] = p2; v.ph[3] = p3; v.ph[4] = p4;
        tbl.push_back(v);
    endfunction

    // Drive one cycle: real opcode only in DECODE, noise elsewhere; then compare at negedge
    task automatic step(input vec_t v, input phase_t p, input int cyc);
        logic [17:0] e;
        if (p == P_D || p == P_DILL) begin
            op = v.op; funct = v.funct;
        end else begin
            op = 6'($urandom); funct = 6'($urandom);
        end
        zout    = (p == P_BEQ)  ? v.z : 1'($urandom);
        signout = (p == P_BLTZ) ? v.s : 1'($urandom);
        sb_q.push_back(exp_vec(p, v));
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s cyc%0d got=%h exp=%h", v.name, cyc, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, input int first, input int last);
        for (int k = first; k < last; k++) step(v, v.ph[k], k + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        add("lw",      6'h23, 6'h00, 0, 0, 5, P_F, P_D, P_MA,  P_MR,  P_MWB);
        add("sw",      6'h2B, 6'h11, 0, 0, 4, P_F, P_D, P_MA,  P_MWR, P_F);
        add("add",     6'h00, 6'h20, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);
        add("sub",     6'h00, 6'h22, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);
        add("and",     6'h00, 6'h24, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);
        add("or",      6'h00, 6'h25, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);
        add("slt",     6'h00, 6'h2A, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);
        add("beq_t",   6'h04, 6'h00, 1, 0, 3, P_F, P_D, P_BEQ, P_F,   P_F);
        add("beq_nt",  6'h04, 6'h00, 0, 1, 3, P_F, P_D, P_BEQ, P_F,   P_F);
        add("bltz_t",  OP_BLTZ, 6'h00, 0, 1, 3, P_F, P_D, P_BLTZ, P_F, P_F);
        add("bltz_nt", OP_BLTZ, 6'h00, 1, 0, 3, P_F, P_D, P_BLTZ, P_F, P_F);
        add("j",       OP_J,  6'h00, 0, 0, 3, P_F, P_D, P_J,   P_F,   P_F);
        add("ill_op",  6'h3F, 6'h20, 0, 0, 2, P_F, P_DILL, P_F, P_F,  P_F);
        add("ill_fn",  6'h00, 6'h3F, 0, 0, 2, P_F, P_DILL, P_F, P_F,  P_F);
        add("slt2",    6'h00, 6'h2A, 0, 0, 4, P_F, P_D, P_RX,  P_RWB, P_F);

        rst = 1'b1; op = 6'h00; funct = 6'h00; zout = 1'b0; signout = 1'b0;
        rv.name = "reset"; rv.op = 0; rv.funct = 0; rv.z = 0; rv.s = 0; rv.len = 1;
        for (int i = 0; i < 5; i++) rv.ph[i] = P_RST;
        for (int c = 0; c < 3; c++) begin
            sb_q.push_back(exp_vec(P_RST, rv));
            @(negedge clk);
            checks++;
            if (got !== sb_q[0]) begin
                errors++;
                $display("FAIL reset cyc%0d got=%h exp=%h", c, got, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], 0, tbl[i].len);

        // Reset during MEMRD of a load: write-back must never happen
        run(tbl[0], 0, 3);
        rst = 1'b1;
        rv.name = "lw_rst";
        step(rv, P_RST, 4);
        rst = 1'b0;
        run(tbl[1], 0, tbl[1].len);
        run(tbl[0], 0, tbl[0].len);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
